// File: rtl/core_pkg.sv
// Shared iexec types: fetch/issue FSM states, request/response packets, next-PC helper.
// No logic and no latency; backpressure lives in the modules that use these types.
// Packets are fixed at the core's 32-bit address and instruction width.
package core_pkg;

    localparam int IEXEC_AW   = 32;
    localparam int IEXEC_DW   = 32;
    localparam int ILEN_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        ISSUE,
        HALT
    } ifu_state_e;

    typedef struct packed {
        logic [IEXEC_DW-1:0] ir;
        logic [IEXEC_AW-1:0] pc;
    } iexec_req_t;

    typedef struct packed {
        logic                taken;
        logic [IEXEC_AW-1:0] offset;
    } iexec_rsp_t;

    // The offset is two's complement, so a plain add gives backward branches and wraps mod 2^AW.
    function automatic logic [IEXEC_AW-1:0] next_pc(
        input logic [IEXEC_AW-1:0] pc,
        input logic                taken,
        input logic [IEXEC_AW-1:0] offset
    );
        return taken ? pc + offset : pc + IEXEC_AW'(ILEN_BYTES);
    endfunction

endpackage

// File: rtl/ifu_issue_if.sv
// iexec request/response bundle between the fetch unit (master) and the EXU (slave).
// No latency of its own; response fields are meaningful only in the req_vld & req_rdy cycle.
// Backpressure: the master holds req_vld and req_pkt stable while req_rdy is low.
interface iexec_if_t;
    import core_pkg::*;

    logic       req_vld;
    logic       req_rdy;
    iexec_req_t req_pkt;
    iexec_rsp_t rsp_pkt;

    modport master (
        output req_vld,
        output req_pkt,
        input  req_rdy,
        input  rsp_pkt
    );

    modport slave (
        input  req_vld,
        input  req_pkt,
        output req_rdy,
        output rsp_pkt
    );

endinterface

// File: rtl/ifu_issue.sv
// Fetch unit: owns the PC, fetches one word at a time, issues it to the EXU, then redirects.
// Latency: 3 cycles per instruction (2 with a same-cycle fetch response).
// Backpressure: waits indefinitely on ibus_req_rdy and iexec req_rdy; it never retracts a request.
module ifu_issue
    import core_pkg::*;
#(
    parameter int            AW       = IEXEC_AW,
    parameter int            DW       = IEXEC_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ibus_req_vld,
    input  logic          ibus_req_rdy,
    output logic [AW-1:0] ibus_req_addr,
    input  logic          ibus_rsp_vld,
    input  logic [DW-1:0] ibus_rsp_data,
    iexec_if_t.master     iexec,
    output logic [AW-1:0] pc_o,
    output logic [31:0]   issue_cnt,
    output logic          err
);

    ifu_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ibus_vld_q, ibus_vld_d;
    logic          iexec_vld_q, iexec_vld_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          ibus_acc;
    logic          iexec_hs;
    logic [AW-1:0] tgt_pc;

    assign ibus_acc = ibus_vld_q & ibus_req_rdy;
    assign iexec_hs = iexec_vld_q & iexec.req_rdy;
    assign tgt_pc   = next_pc(pc_q, iexec.rsp_pkt.taken, iexec.rsp_pkt.offset);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ibus_vld_d  = ibus_vld_q;
        iexec_vld_d = iexec_vld_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        case (state_q)
            FETCH_REQ: begin
                // The request valid rises one cycle after reset release, so any response
                // still in flight from before the reset cannot pair with an accept.
                ibus_vld_d = 1'b1;
                if (ibus_acc) begin
                    ibus_vld_d = 1'b0;
                    if (ibus_rsp_vld) begin
                        ir_d        = ibus_rsp_data;
                        iexec_vld_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        state_d = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                if (ibus_rsp_vld) begin
                    ir_d        = ibus_rsp_data;
                    iexec_vld_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (iexec_hs) begin
                    cnt_d       = cnt_q + 32'd1;
                    iexec_vld_d = 1'b0;
                    if (tgt_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d       = tgt_pc;
                        ibus_vld_d = 1'b1;
                        state_d    = FETCH_REQ;
                    end
                end
            end
            HALT: begin
                ibus_vld_d  = 1'b0;
                iexec_vld_d = 1'b0;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_REQ;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ibus_vld_q  <= 1'b0;
            iexec_vld_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ibus_vld_q  <= ibus_vld_d;
            iexec_vld_q <= iexec_vld_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign ibus_req_vld       = ibus_vld_q;
    assign ibus_req_addr      = pc_q;
    assign iexec.req_vld      = iexec_vld_q;
    assign iexec.req_pkt.ir   = ir_q;
    assign iexec.req_pkt.pc   = pc_q;
    assign pc_o               = pc_q;
    assign issue_cnt          = cnt_q;
    assign err                = err_q;

endmodule

// File: tb/tb_ifu_issue.sv
// Bench for ifu_issue: memory and EXU models drive inputs; a scoreboard checks every fetch and issue.
module tb_ifu_issue;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_req_vld;
    logic        ibus_req_rdy;
    logic [31:0] ibus_req_addr;
    logic        ibus_rsp_vld;
    logic [31:0] ibus_rsp_data;
    logic [31:0] pc_o;
    logic [31:0] issue_cnt;
    logic        err;

    iexec_if_t iexec ();

    ifu_issue #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ibus_req_vld  (ibus_req_vld),
        .ibus_req_rdy  (ibus_req_rdy),
        .ibus_req_addr (ibus_req_addr),
        .ibus_rsp_vld  (ibus_rsp_vld),
        .ibus_rsp_data (ibus_rsp_data),
        .iexec         (iexec),
        .pc_o          (pc_o),
        .issue_cnt     (issue_cnt),
        .err           (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch[$];
    logic [63:0] exp_issue[$];
    int          budget = 0;
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic        exu_rdy = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_off = '0;
    logic [7:0]  gen = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], gen, 8'h13};
    endfunction

    task automatic push(input logic [31:0] pc);
        exp_fetch.push_back(pc);
        exp_issue.push_back({mem_word(pc), pc});
    endtask

    // Memory and EXU models, driven a little after each rising edge.
    initial begin
        ibus_req_rdy  = 1'b0;
        ibus_rsp_vld  = 1'b0;
        ibus_rsp_data = '0;
        iexec.req_rdy = 1'b0;
        iexec.rsp_pkt = '0;
        forever begin
            @(posedge clk);
            #2;
            ibus_rsp_vld  = 1'b0;
            ibus_rsp_data = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    ibus_rsp_vld  = 1'b1;
                    ibus_rsp_data = pend_data;
                end
            end
            ibus_req_rdy = (budget > 0);
            if (ibus_req_vld && ibus_req_rdy) begin
                budget--;
                if (lat == 0) begin
                    ibus_rsp_vld  = 1'b1;
                    ibus_rsp_data = mem_word(ibus_req_addr);
                end else begin
                    pend_cnt  = lat;
                    pend_data = mem_word(ibus_req_addr);
                end
            end
            iexec.req_rdy = exu_rdy;
            if (iexec.req_vld && br_en && iexec.req_pkt.pc == br_pc)
                iexec.rsp_pkt = '{taken: 1'b1, offset: br_off};
            else if (iexec.req_vld)
                iexec.rsp_pkt = '{taken: 1'b0, offset: $urandom};
            else
                iexec.rsp_pkt = '{taken: 1'b1, offset: $urandom};
        end
    end

    // Scoreboard: every accepted fetch and every iexec handshake is matched in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ibus_req_vld && ibus_req_rdy) begin
                if (exp_fetch.size() == 0)
                    chk("fetch_extra", {32'h0, ibus_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    chk("fetch_addr", {32'h0, ibus_req_addr}, {32'h0, exp_fetch.pop_front()});
            end
            if (rst_n && iexec.req_vld && iexec.req_rdy) begin
                if (exp_issue.size() == 0)
                    chk("issue_extra", iexec.req_pkt, 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    chk("issue_pkt", iexec.req_pkt, exp_issue.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        budget = 0;
        exp_fetch.delete();
        exp_issue.delete();
        repeat (2) @(negedge clk);
        chk("rst_ibus_vld", ibus_req_vld, 0);
        chk("rst_iexec_vld", iexec.req_vld, 0);
        chk("rst_pkt", iexec.req_pkt, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_fetch.size() != 0 || exp_issue.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_fetch.size() + exp_issue.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Straight-line stream, 1-cycle memory then zero-wait memory.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            lat = (m == 0) ? 1 : 0;
            gen = 8'h01 + 8'(m);
            exu_rdy = 1'b1;
            br_en = 1'b0;
            push(32'h0); push(32'h4); push(32'h8);
            budget = 3;
            drain(100);
            chk("seq_cnt", issue_cnt, 3);
            chk("seq_pc", pc_o, 32'hC);
            chk("seq_next_req", ibus_req_vld, 1);
        end

        // Forward taken branch.
        do_reset();
        lat = 1; gen = 8'h10;
        br_en = 1'b1; br_pc = 32'h0; br_off = 32'h10;
        push(32'h0); push(32'h10);
        budget = 2;
        drain(100);
        chk("br_cnt", issue_cnt, 2);
        chk("br_pc", pc_o, 32'h14);

        // EXU stalls in ISSUE for 5 cycles.
        do_reset();
        gen = 8'h20; br_en = 1'b0; exu_rdy = 1'b0;
        push(32'h0);
        budget = 1;
        begin
            int n = 0;
            while (!iexec.req_vld && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("stall_issue_seen", iexec.req_vld, 1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_vld", iexec.req_vld, 1);
            chk("stall_pkt", iexec.req_pkt, {mem_word(32'h0), 32'h0});
            chk("stall_nofetch", ibus_req_vld, 0);
            chk("stall_cnt", issue_cnt, 0);
            @(negedge clk);
        end
        exu_rdy = 1'b1;
        drain(50);
        chk("stall_done_cnt", issue_cnt, 1);

        // Backward branch from 0x20 to 0x18.
        do_reset();
        gen = 8'h30; br_en = 1'b1; br_pc = 32'h20; br_off = 32'hFFFF_FFF8;
        for (int a = 0; a <= 32'h20; a += 4) push(32'(a));
        push(32'h18);
        budget = 10;
        drain(300);
        chk("back_cnt", issue_cnt, 10);
        chk("back_pc", pc_o, 32'h1C);

        // Jump to the top of the address space, then wrap to 0 on fall-through.
        do_reset();
        gen = 8'h40; br_en = 1'b1; br_pc = 32'h0; br_off = 32'hFFFF_FFFC;
        push(32'h0); push(32'hFFFF_FFFC); push(32'h0);
        budget = 3;
        drain(100);
        chk("wrap_cnt", issue_cnt, 3);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);

        // Misaligned target halts with a sticky error; reset recovers.
        do_reset();
        gen = 8'h50; br_en = 1'b1; br_pc = 32'h0; br_off = 32'h6;
        push(32'h0);
        budget = 4;
        drain(100);
        for (int k = 0; k < 5; k++) begin
            chk("halt_no_fetch", ibus_req_vld, 0);
            chk("halt_no_issue", iexec.req_vld, 0);
            @(negedge clk);
        end
        chk("halt_err", err, 1);
        chk("halt_cnt", issue_cnt, 1);
        chk("halt_pc", pc_o, 0);
        do_reset();
        gen = 8'h51; br_en = 1'b0;
        push(32'h0);
        budget = 1;
        drain(100);
        chk("recover_err", err, 0);
        chk("recover_cnt", issue_cnt, 1);

        // Reset while waiting on a slow fetch; the late response must be dropped.
        do_reset();
        lat = 4; gen = 8'h66; br_en = 1'b0; exu_rdy = 1'b1;
        exp_fetch.push_back(32'h0);
        budget = 1;
        begin
            int n = 0;
            while (budget != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
        chk("wait_no_fetch", ibus_req_vld, 0);
        chk("wait_no_issue", iexec.req_vld, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pc", pc_o, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("stale_no_issue", iexec.req_vld, 0);
        chk("stale_cnt", issue_cnt, 0);
        chk("stale_refetch_req", ibus_req_vld, 1);
        lat = 1; gen = 8'h77;
        push(32'h0);
        budget = 1;
        drain(100);
        chk("fresh_cnt", issue_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
